// File: rtl/vector_to_float32_serializer_pkg.sv
// Shared types and constants for the vector datapath and its float32 export path.
package vector_to_float32_serializer_pkg;

    // Signed fixed-point component: 12 integer bits, 20 fractional bits
    typedef logic signed [31:0] single_t;

    // One point as packed {x, y, z}, x in the most significant word
    typedef struct packed {
        single_t x;
        single_t y;
        single_t z;
    } point_t;

    // IEEE-754 binary32 word
    typedef logic [31:0] float32_t;

    localparam int float32_bias      = 127;
    localparam int float32_mant_bits = 23;
    localparam int single_frac_bits  = 20;

endpackage

// File: rtl/vector_to_float32_serializer_fixed_to_float32.sv
// Combinational Q12.20 -> binary32 converter with optional round-to-nearest-even.
import vector_to_float32_serializer_pkg::*;

module fixed_to_float32 #(
    parameter bit ROUND_NEAREST_EVEN = 1'b1
) (
    input  single_t  i_value,
    output float32_t o_word,
    output logic     o_inexact
);

    logic        w_sign;
    logic [31:0] w_raw;
    logic [31:0] w_mag;
    logic [31:0] w_lowMask;
    logic [4:0]  w_leadPos;
    logic [7:0]  w_expo;
    logic [22:0] w_mant;
    logic [23:0] w_mantInc;
    logic        w_guard;
    logic        w_sticky;
    logic        w_roundUp;

    // Normalise the magnitude, narrow to 23 mantissa bits and round or truncate
    always_comb begin
        w_raw     = i_value;
        w_sign    = w_raw[31];
        w_mag     = w_sign ? (~w_raw + 32'd1) : w_raw;
        w_leadPos = 5'd0;
        w_lowMask = 32'd0;
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        w_mant    = 23'd0;
        w_mantInc = 24'd0;
        w_roundUp = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) begin
                w_leadPos = 5'(i);
            end
        end
        w_expo = 8'(w_leadPos) + 8'(float32_bias - single_frac_bits);
        if (w_leadPos <= 5'(float32_mant_bits)) begin
            w_mant = 23'(w_mag << (5'(float32_mant_bits) - w_leadPos));
        end else begin
            w_mant    = 23'(w_mag >> (w_leadPos - 5'(float32_mant_bits)));
            w_guard   = w_mag[w_leadPos - 5'd24];
            w_lowMask = (32'd1 << (w_leadPos - 5'd24)) - 32'd1;
            w_sticky  = |(w_mag & w_lowMask);
        end
        w_roundUp = ROUND_NEAREST_EVEN && w_guard && (w_sticky || w_mant[0]);
        w_mantInc = {1'b0, w_mant} + {23'd0, w_roundUp};
        if (w_mantInc[23]) begin
            w_mant = 23'd0;
            w_expo = w_expo + 8'd1;
        end else begin
            w_mant = w_mantInc[22:0];
        end
        if (w_mag == 32'd0) begin
            o_word    = 32'd0;
            o_inexact = 1'b0;
        end else begin
            o_word    = {w_sign, w_expo, w_mant};
            o_inexact = w_guard | w_sticky;
        end
    end

endmodule

// File: rtl/vector_to_float32_serializer.sv
// Captures one point and streams its x, y, z components as binary32 words.
import vector_to_float32_serializer_pkg::*;

module vector_to_float32_serializer #(
    parameter bit ROUND_NEAREST_EVEN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_point,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [1:0]  out_index,
    output logic        out_last,
    output logic        out_inexact
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     r_state;
    point_t     r_point;
    logic [1:0] r_idx;
    logic       r_inReady;
    logic       r_outValid;
    float32_t   r_outWord;
    logic [1:0] r_outIndex;
    logic       r_outLast;
    logic       r_outInexact;
    single_t    w_component;
    float32_t   w_word;
    logic       w_inexact;

    // Select the captured component currently being converted
    always_comb begin
        case (r_idx)
            2'd0:    w_component = r_point.x;
            2'd1:    w_component = r_point.y;
            default: w_component = r_point.z;
        endcase
    end

    fixed_to_float32 #(
        .ROUND_NEAREST_EVEN(ROUND_NEAREST_EVEN)
    ) u_convert (
        .i_value  (w_component),
        .o_word   (w_word),
        .o_inexact(w_inexact)
    );

    // Capture / convert / hold sequencer with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_point      <= '0;
            r_idx        <= 2'd0;
            r_inReady    <= 1'b0;
            r_outValid   <= 1'b0;
            r_outWord    <= '0;
            r_outIndex   <= 2'd0;
            r_outLast    <= 1'b0;
            r_outInexact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_point   <= in_point;
                        r_idx     <= 2'd0;
                        r_inReady <= 1'b0;
                        r_state   <= CONV;
                    end else begin
                        r_inReady <= 1'b1;
                    end
                end
                CONV: begin
                    r_outWord    <= w_word;
                    r_outIndex   <= r_idx;
                    r_outLast    <= (r_idx == 2'd2);
                    r_outInexact <= w_inexact;
                    r_outValid   <= 1'b1;
                    r_state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        if (r_idx == 2'd2) begin
                            r_inReady <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= CONV;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_outValid;
    assign out_word    = r_outWord;
    assign out_index   = r_outIndex;
    assign out_last    = r_outLast;
    assign out_inexact = r_outInexact;

endmodule
